// File: rtl/reaction_ctrl.sv
// rtl/reaction_ctrl.sv - reaction-timer game controller
// Sequences start lights, random hold and reaction timing; keeps last and best times.
module reaction_ctrl #(
  parameter int MAX_MS     = 9999,
  parameter int LIGHTS_TMO = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_ms,
  input  logic        start_btn,
  input  logic        react_btn,
  input  logic        lights_done,
  input  logic        time_out,
  output logic        trigger,
  output logic [13:0] rt_ms,
  output logic [13:0] best_ms,
  output logic        result_valid,
  output logic        false_start,
  output logic        fault,
  output logic        busy
);

  localparam logic [13:0] LP_MAX = 14'(MAX_MS);
  localparam logic [13:0] LP_TMO = 14'(LIGHTS_TMO);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_LIGHTS, S_HOLD, S_TIMING, S_RESULT, S_FALSE, S_FAULT
  } state_t;

  state_t      r_state;
  logic [13:0] r_cnt;
  logic        r_trigger;
  logic [13:0] r_rt_ms;
  logic [13:0] r_best_ms;
  logic        r_result_valid;
  logic        r_false_start;
  logic        r_fault;
  logic        r_busy;

  logic [13:0] w_cnt_inc;
  assign w_cnt_inc = r_cnt + 14'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_trigger      <= 1'b0;
      r_rt_ms        <= '0;
      r_best_ms      <= LP_MAX;
      r_result_valid <= 1'b0;
      r_false_start  <= 1'b0;
      r_fault        <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_trigger <= 1'b0;
      case (r_state)
        S_IDLE, S_RESULT, S_FALSE, S_FAULT: begin
          if (start_btn) begin
            r_state        <= S_ARM;
            r_trigger      <= 1'b1;
            r_result_valid <= 1'b0;
            r_false_start  <= 1'b0;
            r_fault        <= 1'b0;
            r_busy         <= 1'b1;
            r_cnt          <= '0;
          end
        end
        S_ARM: begin
          r_state <= S_LIGHTS;
        end
        S_LIGHTS: begin
          if (react_btn) begin
            r_state       <= S_FALSE;
            r_false_start <= 1'b1;
            r_busy        <= 1'b0;
          end else if (lights_done) begin
            r_state <= S_HOLD;
          end else if (tick_ms) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc >= LP_TMO) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        // A response coinciding with time_out still counts as anticipating the lights.
        S_HOLD: begin
          if (react_btn) begin
            r_state       <= S_FALSE;
            r_false_start <= 1'b1;
            r_busy        <= 1'b0;
          end else if (time_out) begin
            r_state <= S_TIMING;
            r_cnt   <= '0;
          end
        end
        S_TIMING: begin
          if (react_btn) begin
            r_state        <= S_RESULT;
            r_rt_ms        <= r_cnt;
            r_result_valid <= 1'b1;
            r_busy         <= 1'b0;
            if (r_cnt < r_best_ms && r_cnt != LP_MAX)
              r_best_ms <= r_cnt;
          end else if (tick_ms) begin
            if (w_cnt_inc >= LP_MAX) begin
              r_cnt          <= LP_MAX;
              r_state        <= S_RESULT;
              r_rt_ms        <= LP_MAX;
              r_result_valid <= 1'b1;
              r_busy         <= 1'b0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign trigger      = r_trigger;
  assign rt_ms        = r_rt_ms;
  assign best_ms      = r_best_ms;
  assign result_valid = r_result_valid;
  assign false_start  = r_false_start;
  assign fault        = r_fault;
  assign busy         = r_busy;

endmodule

// File: tb/tb_reaction_ctrl.sv
// tb/tb_reaction_ctrl.sv - directed self-checking bench for reaction_ctrl
module tb_reaction_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick_ms, start_btn, react_btn, lights_done, time_out;
  logic        trigger;
  logic [13:0] rt_ms, best_ms;
  logic        result_valid, false_start, fault, busy;

  int n_err = 0;
  int n_chk = 0;
  int trig_cnt = 0;

  always #5 clk = ~clk;

  reaction_ctrl #(.MAX_MS(9999), .LIGHTS_TMO(2000)) dut (
    .clk(clk), .rst_n(rst_n), .tick_ms(tick_ms), .start_btn(start_btn),
    .react_btn(react_btn), .lights_done(lights_done), .time_out(time_out),
    .trigger(trigger), .rt_ms(rt_ms), .best_ms(best_ms),
    .result_valid(result_valid), .false_start(false_start), .fault(fault), .busy(busy)
  );

  always @(negedge clk) if (trigger) trig_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick_ms = 1'b1;
      @(negedge clk) tick_ms = 1'b0;
    end
  endtask

  task automatic press_start();
    @(negedge clk) start_btn = 1'b1;
    @(negedge clk) start_btn = 1'b0;
  endtask

  task automatic press_react();
    @(negedge clk) react_btn = 1'b1;
    @(negedge clk) react_btn = 1'b0;
  endtask

  task automatic lights(input int n);
    ticks(n);
    @(negedge clk) lights_done = 1'b1;
    @(negedge clk) lights_done = 1'b0;
  endtask

  task automatic go();
    @(negedge clk) time_out = 1'b1;
    @(negedge clk) time_out = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick_ms = 1'b0; start_btn = 1'b0; react_btn = 1'b0;
    lights_done = 1'b0; time_out = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rt", rt_ms, 0);
    chk("rst_best", best_ms, 9999);
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // run 1: reaction 237
    press_start();
    chk("r1_trigger", trigger, 1);
    chk("r1_busy_arm", busy, 1);
    lights(500);
    chk("r1_busy_hold", busy, 1);
    go();
    ticks(237);
    press_react();
    chk("r1_rt", rt_ms, 237);
    chk("r1_best", best_ms, 237);
    chk("r1_valid", result_valid, 1);
    chk("r1_busy", busy, 0);
    chk("r1_trig_low", trigger, 0);

    // run 2: slower reaction keeps best
    press_start();
    chk("r2_valid_clr", result_valid, 0);
    lights(500);
    go();
    ticks(300);
    press_react();
    chk("r2_rt", rt_ms, 300);
    chk("r2_best", best_ms, 237);

    // run 3: react coincides with a tick; that tick is excluded
    press_start();
    lights(10);
    go();
    ticks(180);
    @(negedge clk) begin tick_ms = 1'b1; react_btn = 1'b1; end
    @(negedge clk) begin tick_ms = 1'b0; react_btn = 1'b0; end
    chk("r3_rt", rt_ms, 180);
    chk("r3_best", best_ms, 180);

    // false start: react together with time_out in HOLD
    press_start();
    lights(5);
    @(negedge clk) begin react_btn = 1'b1; time_out = 1'b1; end
    @(negedge clk) begin react_btn = 1'b0; time_out = 1'b0; end
    chk("fs_flag", false_start, 1);
    chk("fs_rt", rt_ms, 180);
    chk("fs_best", best_ms, 180);
    chk("fs_busy", busy, 0);
    chk("fs_valid", result_valid, 0);
    press_start();
    chk("fs_clr", false_start, 0);
    chk("fs_trigger", trigger, 1);

    // saturation, with an ignored start mid-timing
    lights(3);
    go();
    ticks(5000);
    press_start();
    chk("sat_ign_busy", busy, 1);
    chk("sat_ign_trig", trigger, 0);
    ticks(5000);
    chk("sat_rt", rt_ms, 9999);
    chk("sat_valid", result_valid, 1);
    chk("sat_best", best_ms, 180);
    chk("sat_busy", busy, 0);

    // false start during LIGHTS
    press_start();
    ticks(5);
    press_react();
    chk("fsl_flag", false_start, 1);
    chk("fsl_rt", rt_ms, 9999);

    // lights timeout
    press_start();
    ticks(1999);
    chk("tmo_pre_fault", fault, 0);
    chk("tmo_pre_busy", busy, 1);
    ticks(1);
    chk("tmo_fault", fault, 1);
    chk("tmo_busy", busy, 0);
    press_start();
    chk("tmo_clr", fault, 0);
    chk("tmo_trigger", trigger, 1);

    // asynchronous reset mid-timing
    lights(2);
    go();
    ticks(50);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_rt", rt_ms, 0);
    chk("ar_best", best_ms, 9999);
    chk("ar_busy", busy, 0);
    chk("ar_valid", result_valid, 0);
    chk("ar_trig", trigger, 0);
    chk("ar_fault", fault, 0);
    chk("ar_fs", false_start, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("ar_idle_busy", busy, 0);
    chk("ar_idle_valid", result_valid, 0);

    press_start();
    lights(4);
    go();
    ticks(42);
    press_react();
    chk("pr_rt", rt_ms, 42);
    chk("pr_best", best_ms, 42);
    chk("pr_valid", result_valid, 1);

    repeat (2) @(negedge clk);
    chk("trig_count", trig_cnt, 9);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/reaction_ctrl.md
REACTION_CTRL -- requirements
Module: reaction_ctrl

Interface
REQ-001 Parameter MAX_MS, default 9999: reaction-time saturation limit, in ms.
REQ-002 Parameter LIGHTS_TMO, default 2000: ms allowed for the lights sequence before fault.
REQ-003 Port clk, input, 1: single system clock; all logic is rising-edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port tick_ms, input, 1: one-cycle pulse, once per millisecond.
REQ-006 Port start_btn, input, 1: debounced one-cycle start request.
REQ-007 Port react_btn, input, 1: debounced one-cycle player response.
REQ-008 Port lights_done, input, 1: level high when the start-light sequencer shows all 10 LEDs lit.
REQ-009 Port time_out, input, 1: level high when the random hold delay has expired.
REQ-010 Port trigger, output, 1: one-cycle pulse that launches the start-light sequencer.
REQ-011 Port rt_ms, output, 14: last reaction time, in ms.
REQ-012 Port best_ms, output, 14: best valid reaction time since reset.
REQ-013 Port result_valid, output, 1: high while rt_ms holds a fresh valid result.
REQ-014 Port false_start, output, 1: high while a false start is latched.
REQ-015 Port fault, output, 1: high while a lights-sequence timeout is latched.
REQ-016 Port busy, output, 1: high in every state except IDLE, RESULT, FALSE and FAULT.

Function
REQ-017 The block SHALL implement the FSM states IDLE, ARM, LIGHTS, HOLD, TIMING, RESULT, FALSE and FAULT.
REQ-018 IDLE, RESULT, FALSE and FAULT SHALL go to ARM on start_btn; all other inputs are ignored in these states.
REQ-019 ARM SHALL last exactly one cycle, assert trigger in that cycle, clear result_valid, false_start and fault, and go to LIGHTS.
REQ-020 LIGHTS SHALL go to HOLD in the cycle after lights_done is sampled high.
REQ-021 LIGHTS SHALL count tick_ms; reaching LIGHTS_TMO SHALL go to FAULT.
REQ-022 HOLD SHALL go to TIMING when time_out is sampled high, and SHALL clear the ms counter to 0 on that transition.
REQ-023 react_btn in LIGHTS or HOLD SHALL go to FALSE, with rt_ms unchanged.
REQ-024 react_btn and time_out in the same HOLD cycle SHALL be treated as a false start.
REQ-025 TIMING SHALL increment the ms counter on each tick_ms, saturating at MAX_MS.
REQ-026 react_btn in TIMING SHALL load rt_ms with the counter value and go to RESULT, with 1-cycle latency.
REQ-027 When tick_ms and react_btn coincide in TIMING, the captured value SHALL exclude that tick.
REQ-028 A counter reaching MAX_MS in TIMING SHALL load rt_ms = MAX_MS and go to RESULT.
REQ-029 Entering RESULT SHALL set result_valid.
REQ-030 Entering RESULT SHALL update best_ms when rt_ms < best_ms and rt_ms != MAX_MS.
REQ-031 start_btn in LIGHTS, HOLD or TIMING SHALL be ignored.
REQ-032 All outputs SHALL be registered; trigger is the only pulsed output.
REQ-033 Counters are 14-bit unsigned; no wrap-around is permitted.

Reset
REQ-034 rst_n low SHALL immediately force state IDLE, trigger 0, rt_ms 0, best_ms = MAX_MS, result_valid 0, false_start 0, fault 0, busy 0, and clear all counters.
REQ-035 Reset asserted mid-sequence SHALL abort without any result or best_ms update.
REQ-036 Release SHALL be synchronous to clk; the first active edge after release evaluates IDLE.

Verification
REQ-037 Normal run: start_btn; lights_done after 500 ticks; time_out; react_btn after 237 ticks -> one trigger pulse, rt_ms = 237, best_ms = 237, result_valid = 1.
REQ-038 Second run with a reaction of 300 ticks -> rt_ms = 300, best_ms stays 237; a following run of 180 -> best_ms = 180.
REQ-039 react_btn during HOLD -> false_start = 1, FALSE state, rt_ms and best_ms unchanged; next start_btn clears false_start.
REQ-040 No react_btn for 10000 ticks in TIMING -> rt_ms = 9999, result_valid = 1, best_ms unchanged.
REQ-041 lights_done held low for 2000 ticks -> fault = 1, busy = 0; start_btn retriggers.
REQ-042 rst_n pulsed low mid-TIMING, including asynchronously between edges -> outputs at reset values immediately, best_ms = 9999, IDLE after release.
